// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
//
// Purpose: operation encoding (funct3), FSM state type, special-case result
// constants and small decode helpers used by muldiv_ctrl, md_datapath and
// muldiv_ctrl_if.
// Ports: none (package).
package control_pkg;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_OVF_Q  = 32'h8000_0000;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  // REM/REMU share funct3[1] = 1 within the divide group
  function automatic logic md_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_rs1_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_rs2_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage handshake bundle between the pipeline and muldiv_ctrl
//
// Purpose: groups the request (start/op/operands/flush) and response
// (stall/busy/done/result) signals of the multiply/divide sequencer.
// Modports:
//   master - pipeline side: drives start, op, rs1_val, rs2_val, flush
//   slave  - sequencer side: drives stall, busy, done, result
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  import control_pkg::*;

  logic            start;
  md_op_e          op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1_val, rs2_val, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, flush,
    output stall, busy, done, result
  );

endinterface

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - accumulator, shift-add / restoring shift-subtract step and sign fix-up
//
// Purpose: holds the latched op, operand magnitudes, sign flags, the 64-bit
// accumulator ({hi,lo} product or {remainder,quotient}) and the result word.
// Optional feature macro: MULDIV_FAST_MUL_EN (combinational 33x33 multiplier
// feeding the IDLE->DONE fast path for the four multiply ops).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load              - latch op/operands from the request (IDLE accept)
//   step              - advance one iteration of the loop
//   finish            - capture the final result word this edge
//   op_in, rs1_val, rs2_val - raw request from the pipeline
//   special           - request is divide-by-zero or signed overflow
//   result            - registered result, holds until the next finish
module md_datapath
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        finish,
  input  md_op_e      op_in,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        special,
  output logic [31:0] result
);

  md_op_e      op_q, op_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  // request decode
  logic        in_is_div, in_neg_a, in_neg_b, div0, ovf;
  logic [31:0] mag_a, mag_b, special_word, idle_word;

  always_comb begin
    in_is_div = md_is_div(op_in);
    in_neg_a  = md_rs1_signed(op_in) & rs1_val[31];
    in_neg_b  = md_rs2_signed(op_in) & rs2_val[31];
    mag_a     = in_neg_a ? (~rs1_val + 32'd1) : rs1_val;
    mag_b     = in_neg_b ? (~rs2_val + 32'd1) : rs2_val;
    div0      = in_is_div && (rs2_val == 32'd0);
    ovf       = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                (rs1_val == MD_OVF_Q) && (rs2_val == 32'hFFFF_FFFF);
    special   = div0 | ovf;
    if (div0) begin
      special_word = md_is_rem(op_in) ? rs1_val : MD_DIV0_Q;
    end else begin
      special_word = md_is_rem(op_in) ? 32'd0 : MD_OVF_Q;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extend each operand by one bit so one signed multiplier covers
  // MULH, MULHSU and MULHU alike.
  logic signed [32:0] fm_a, fm_b;
  logic signed [63:0] fm_p;

  always_comb begin
    fm_a = {md_rs1_signed(op_in) & rs1_val[31], rs1_val};
    fm_b = {md_rs2_signed(op_in) & rs2_val[31], rs2_val};
    fm_p = 64'(fm_a) * 64'(fm_b);
    if (special) begin
      idle_word = special_word;
    end else begin
      idle_word = (op_in == MD_MUL) ? fm_p[31:0] : fm_p[63:32];
    end
  end
`else
  assign idle_word = special_word;
`endif

  // one loop iteration
  logic [32:0] mul_sum, div_rem, div_diff;
  logic [63:0] acc_step;

  always_comb begin
    // multiply: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole pair right
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // divide: shift remainder/quotient left, try subtracting the divisor;
    // bit 32 of the difference is the borrow
    div_rem  = acc_q[63:31];
    div_diff = div_rem - {1'b0, opnd_q};
    if (md_is_div(op_q)) begin
      if (!div_diff[32]) begin
        acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_step = {div_rem[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
  end

  // sign correction applied to the last step's value so result is
  // registered on the same edge that enters DONE
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_word;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_step + 64'd1) : acc_step;
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem_fix  = neg_a_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
    if (md_is_div(op_q)) begin
      fix_word = md_is_rem(op_q) ? rem_fix : quo_fix;
    end else begin
      fix_word = (op_q == MD_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

  always_comb begin
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (load) begin
      op_d    = op_in;
      neg_a_d = in_neg_a;
      neg_b_d = in_neg_b;
      opnd_d  = in_is_div ? mag_b : mag_a;
      acc_d   = {32'd0, in_is_div ? mag_a : mag_b};
    end else if (step) begin
      acc_d = acc_step;
    end
    // finish together with load is the IDLE->DONE fast path
    if (finish) begin
      result_d = load ? idle_word : fix_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MD_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle RV32M multiply/divide sequencer for the EX stage
//
// Purpose: IDLE/CALC/DONE control FSM that accepts an M-op, stalls the front
// of the pipeline while md_datapath iterates, and pulses done with result.
// Optional feature macro: MULDIV_FAST_MUL_EN (multiply ops complete in one
// cycle through a combinational multiplier; divides stay iterative).
// Parameters: XLEN (32 only), ITERS (loop iteration count, 32).
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   md       - muldiv_ctrl_if.slave: start/op/rs1_val/rs2_val/flush in,
//              stall/busy/done/result out
module muldiv_ctrl
  import control_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  md
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            accept, special, fast_mul, load, step, finish;
  logic [XLEN-1:0] result_w;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !md_is_div(md.op);
`else
  assign fast_mul = 1'b0;
`endif

  assign accept = (state_q == MD_IDLE) && md.start && !md.flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          load  = 1'b1;
          cnt_d = CNT_W'(ITERS - 1);
          if (special || fast_mul) begin
            finish  = 1'b1;
            state_d = MD_DONE;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // start is ignored here: the same instruction is still in EX
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // a flushed op must neither finish nor disturb result
    if (md.flush) begin
      state_d = MD_IDLE;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
    end
    done_d = (state_d == MD_DONE);
    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  md_datapath u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .op_in   (md.op),
    .rs1_val (md.rs1_val),
    .rs2_val (md.rs2_val),
    .special (special),
    .result  (result_w)
  );

  // stall drops on the DONE cycle so the pipeline advances with the result
  assign md.stall  = !md.flush &&
                     (((state_q == MD_IDLE) && md.start) || (state_q == MD_CALC));
  assign md.busy   = busy_q;
  assign md.done   = done_q;
  assign md.result = result_w;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import control_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(32)) mdif ();

  muldiv_ctrl #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mdif.slave)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic on the architectural definitions
  function automatic logic [31:0] ref_md(input md_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (op == MD_DIV || op == MD_DIVU || op == MD_REM || op == MD_REMU) begin
      if (b == 32'd0) return 1;
      if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return MUL_LAT;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called right after a negedge; issues start this cycle (cycle 0) and
  // returns at the done cycle. stall_cnt counts stall-high cycles before done.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stall_cnt);
    mdif.start   = 1'b1;
    mdif.op      = op;
    mdif.rs1_val = a;
    mdif.rs2_val = b;
    #1;
    stall_cnt = int'(mdif.stall);
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      mdif.start = 1'b0;
      #1;
      if (mdif.done) begin
        lat = c;
        res = mdif.result;
        if (mdif.stall) stall_cnt += 1000;
        break;
      end
      stall_cnt += int'(mdif.stall);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    int          lat, scnt, n_done;
    md_op_e      rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{MD_DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33};
    vecs[1]  = '{MD_REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[2]  = '{MD_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[3]  = '{MD_REMU,   32'd7,         32'd0,         32'd7,         1};
    vecs[4]  = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[5]  = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[6]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[7]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[8]  = '{MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         MUL_LAT};
    vecs[9]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[10] = '{MD_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    vecs[12] = '{MD_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[13] = '{MD_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[14] = '{MD_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 33};
    vecs[15] = '{MD_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33};

    rst = 1'b1;
    mdif.start = 1'b0;
    mdif.flush = 1'b0;
    mdif.op = MD_MUL;
    mdif.rs1_val = 32'd0;
    mdif.rs2_val = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset stall",  32'(mdif.stall), 32'd0);
    chk("reset busy",   32'(mdif.busy),  32'd0);
    chk("reset done",   32'(mdif.done),  32'd0);
    chk("reset result", mdif.result,     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, scnt);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d stall cycles", i), 32'(scnt), 32'(vecs[i].lat));
    end

    // back-to-back MULs; second start first appears during the DONE cycle
    @(negedge clk);
    run_op(MD_MUL, 32'd3, 32'd5, res, lat, scnt);
    chk("b2b first result", res, 32'd15);
    chk("b2b first latency", 32'(lat), 32'(MUL_LAT));
    mdif.start   = 1'b1;
    mdif.op      = MD_MUL;
    mdif.rs1_val = 32'd7;
    mdif.rs2_val = 32'hFFFF_FFFE;
    @(negedge clk);
    #1;
    chk("b2b start ignored in done", 32'(mdif.busy), 32'd0);
    chk("b2b stall in idle with start", 32'(mdif.stall), 32'd1);
    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFE, res, lat, scnt);
    chk("b2b second result", res, 32'hFFFF_FFF2);
    chk("b2b second latency", 32'(lat), 32'(MUL_LAT));
    @(negedge clk);
    #1;
    chk("b2b no extra done", 32'(mdif.done), 32'd0);
    chk("b2b result holds", mdif.result, 32'hFFFF_FFF2);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    mdif.start   = 1'b1;
    mdif.op      = MD_DIVU;
    mdif.rs1_val = 32'd1000;
    mdif.rs2_val = 32'd7;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      mdif.start = 1'b0;
    end
    @(negedge clk);
    mdif.flush = 1'b1;
    #1;
    chk("flush stall drops", 32'(mdif.stall), 32'd0);
    chk("flush busy before edge", 32'(mdif.busy), 32'd1);
    @(negedge clk);
    mdif.flush = 1'b0;
    #1;
    chk("flush idle next", 32'(mdif.busy), 32'd0);
    chk("flush no done", 32'(mdif.done), 32'd0);
    chk("flush result kept", mdif.result, 32'hFFFF_FFF2);
    run_op(MD_DIVU, 32'd1000, 32'd7, res, lat, scnt);
    chk("post-flush result", res, 32'd142);
    chk("post-flush latency", 32'(lat), 32'd33);

    // start and flush together
    @(negedge clk);
    mdif.start   = 1'b1;
    mdif.flush   = 1'b1;
    mdif.op      = MD_DIV;
    mdif.rs1_val = 32'd20;
    mdif.rs2_val = 32'd0;
    #1;
    chk("start+flush stall", 32'(mdif.stall), 32'd0);
    @(negedge clk);
    mdif.start = 1'b0;
    mdif.flush = 1'b0;
    #1;
    chk("start+flush busy", 32'(mdif.busy), 32'd0);
    chk("start+flush done", 32'(mdif.done), 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    mdif.start   = 1'b1;
    mdif.op      = MD_DIVU;
    mdif.rs1_val = 32'd50;
    mdif.rs2_val = 32'd5;
    repeat (5) begin
      @(negedge clk);
      mdif.start = 1'b0;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("mid-reset busy",   32'(mdif.busy),  32'd0);
    chk("mid-reset stall",  32'(mdif.stall), 32'd0);
    chk("mid-reset result", mdif.result,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      n_done += int'(mdif.done);
    end
    chk("mid-reset no done", 32'(n_done), 32'd0);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = md_op_e'($urandom_range(0, 7));
      ra  = rnd_opnd();
      rb  = rnd_opnd();
      @(negedge clk);
      run_op(rop, ra, rb, res, lat, scnt);
      chk($sformatf("rand%0d %s %08h,%08h result", i, rop.name(), ra, rb), res, ref_md(rop, ra, rb));
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(rop, ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
